// File: rtl/t6507lp_alu_sequencer.sv
// Fetches 6507 instruction bytes over a req/ack byte bus and issues each
// decoded instruction to the T6507LP ALU as a single-cycle strobe.
module t6507lp_alu_sequencer #(
  parameter int ADDR_WIDTH = 13,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic                  seq_start,
  input  logic [ADDR_WIDTH-1:0] seq_start_addr,
  input  logic [7:0]            seq_count,
  input  logic                  seq_abort,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_data,
  output logic                  alu_enable,
  output logic [7:0]            alu_opcode,
  output logic [7:0]            alu_a,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  seq_illegal,
  output logic [ADDR_WIDTH-1:0] seq_pc
);

  // state     | meaning
  // S_IDLE    | waiting for seq_start
  // S_FETCH_OP| requesting opcode byte at pc
  // S_FETCH_AR| requesting operand byte at pc
  // S_ISSUE   | alu_enable high for one cycle
  // S_GAP     | settle time after an issue or illegal opcode
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH_OP = 3'd1;
  localparam logic [2:0] S_FETCH_AR = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;

  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            rem_q, rem_d;
  logic [3:0]            gap_q, gap_d;
  logic [7:0]            op_q, op_d;
  logic [7:0]            alu_op_q, alu_op_d;
  logic [7:0]            alu_a_q, alu_a_d;
  logic                  done_q, done_d;
  logic                  ill_q, ill_d;

  logic [7:0]            rem_dec;
  logic [2:0]            after_state;
  logic                  after_done;
  logic                  data_two_byte;
  logic                  data_one_byte;

  assign rem_dec = rem_q - 8'd1;

  always_comb begin
    data_two_byte = ((mem_data[4:0] == 5'b01001) && (mem_data != 8'h89)) ||
                    (mem_data == 8'hA0) || (mem_data == 8'hA2) ||
                    (mem_data == 8'hC0) || (mem_data == 8'hE0);
    data_one_byte = (mem_data[3:0] == 4'h8) || (mem_data[3:0] == 4'hA);
  end

  // Where to go after an issue or illegal opcode; with no gap the GAP exit
  // rule is applied immediately against the already-decremented count.
  always_comb begin
    after_state = S_GAP;
    after_done  = 1'b0;
    if (GAP_CYCLES == 0) begin
      if (rem_dec == 8'd0) begin
        after_state = S_IDLE;
        after_done  = 1'b1;
      end else begin
        after_state = S_FETCH_OP;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    op_d     = op_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          if (seq_count != 8'd0) begin
            pc_d    = seq_start_addr;
            rem_d   = seq_count;
            state_d = S_FETCH_OP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH_OP: begin
        if (seq_abort) begin
          state_d = S_IDLE;
        end else if (mem_ack) begin
          op_d = mem_data;
          pc_d = pc_q + PC_ONE;
          if (data_two_byte) begin
            state_d = S_FETCH_AR;
          end else if (data_one_byte) begin
            alu_op_d = mem_data;
            alu_a_d  = 8'h00;
            state_d  = S_ISSUE;
          end else begin
            ill_d   = 1'b1;
            rem_d   = rem_dec;
            gap_d   = GAP_LOAD;
            state_d = after_state;
            done_d  = after_done;
          end
        end
      end
      S_FETCH_AR: begin
        if (seq_abort) begin
          state_d = S_IDLE;
        end else if (mem_ack) begin
          alu_op_d = op_q;
          alu_a_d  = mem_data;
          pc_d     = pc_q + PC_ONE;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (seq_abort) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = rem_dec;
          gap_d   = GAP_LOAD;
          state_d = after_state;
          done_d  = after_done;
        end
      end
      S_GAP: begin
        if (seq_abort) begin
          state_d = S_IDLE;
        end else if (gap_q == 4'd0) begin
          if (rem_q == 8'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH_OP;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      rem_q    <= 8'd0;
      gap_q    <= 4'd0;
      op_q     <= 8'd0;
      alu_op_q <= 8'd0;
      alu_a_q  <= 8'd0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      op_q     <= op_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
    end
  end

  assign mem_req     = (state_q == S_FETCH_OP) || (state_q == S_FETCH_AR);
  assign mem_addr    = pc_q;
  assign alu_enable  = (state_q == S_ISSUE);
  assign alu_opcode  = alu_op_q;
  assign alu_a       = alu_a_q;
  assign seq_busy    = (state_q != S_IDLE);
  assign seq_done    = done_q;
  assign seq_illegal = ill_q;
  assign seq_pc      = pc_q;

endmodule

// File: tb/tb_t6507lp_alu_sequencer.sv
// Directed bench for t6507lp_alu_sequencer: byte memory with programmable
// wait states, issue/done monitor, hand-computed expectations.
module tb_t6507lp_alu_sequencer;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        seq_start = 1'b0;
  logic [12:0] seq_start_addr = '0;
  logic [7:0]  seq_count = '0;
  logic        seq_abort = 1'b0;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = '0;
  logic        alu_enable;
  logic [7:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_illegal;
  logic [12:0] seq_pc;

  t6507lp_alu_sequencer #(.ADDR_WIDTH(13), .GAP_CYCLES(1)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i),
    .seq_start(seq_start), .seq_start_addr(seq_start_addr),
    .seq_count(seq_count), .seq_abort(seq_abort),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_illegal(seq_illegal), .seq_pc(seq_pc)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // memory model: acks after wait_cfg wait cycles, never acks block_addr
  logic [7:0] mem [0:8191];
  int wait_cfg = 0;
  int block_addr = -1;
  int wcnt = 0;

  always @(negedge clk_i) begin
    if (!mem_req || mem_ack) wcnt = 0;
    if (mem_req && (int'(mem_addr) != block_addr) && (wcnt == wait_cfg)) begin
      mem_ack  = 1'b1;
      mem_data = mem[mem_addr];
    end else begin
      mem_ack = 1'b0;
      if (mem_req) wcnt++;
    end
  end

  // monitor, cycle numbers relative to the edge that sampled seq_start
  int cyc = 0;
  int start_cyc = 0;
  int n_en, n_done, n_ill, done_cyc;
  int en_cyc [8];
  logic [7:0] en_op [8];
  logic [7:0] en_a [8];
  bit busy_seen;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (alu_enable && n_en < 8) begin
      en_cyc[n_en] = cyc - start_cyc + 1;
      en_op[n_en]  = alu_opcode;
      en_a[n_en]   = alu_a;
      n_en++;
    end
    if (seq_done) begin
      if (n_done == 0) done_cyc = cyc - start_cyc + 1;
      n_done++;
    end
    if (seq_illegal) n_ill++;
    if (seq_busy) busy_seen = 1'b1;
  end

  task automatic clear_mon();
    n_en = 0; n_done = 0; n_ill = 0; done_cyc = -1; busy_seen = 1'b0;
  endtask

  task automatic start_seq(input logic [12:0] addr, input logic [7:0] cnt);
    @(negedge clk_i);
    #1;
    clear_mon();
    seq_start_addr = addr;
    seq_count      = cnt;
    seq_start      = 1'b1;
    @(posedge clk_i);
    #1;
    start_cyc = cyc;
    seq_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk_i);
      #1;
      if (n_done != 0) break;
    end
    if (i == budget) check({tag, "_timeout"}, 0, 1);
    repeat (2) @(negedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    clear_mon();
    repeat (3) @(negedge clk_i);
    check("rst_mem_req", mem_req, 0);
    check("rst_alu_enable", alu_enable, 0);
    check("rst_busy", seq_busy, 0);
    n_rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_outputs", {mem_req, alu_enable, seq_busy, seq_done, seq_illegal,
                          alu_opcode, alu_a}, 0);
    check("rst_pc", seq_pc, 0);
    check("rst_addr", mem_addr, 0);

    // basic program A9 05 / 69 03 / 18
    mem[13'h100] = 8'hA9; mem[13'h101] = 8'h05; mem[13'h102] = 8'h69;
    mem[13'h103] = 8'h03; mem[13'h104] = 8'h18;
    wait_cfg = 0;
    start_seq(13'h100, 8'd3);
    wait_done("basic", 60);
    check("basic_n_en", n_en, 3);
    check("basic_cyc0", en_cyc[0], 3);
    check("basic_cyc1", en_cyc[1], 7);
    check("basic_cyc2", en_cyc[2], 10);
    check("basic_issue0", {en_op[0], en_a[0]}, 16'hA905);
    check("basic_issue1", {en_op[1], en_a[1]}, 16'h6903);
    check("basic_issue2", {en_op[2], en_a[2]}, 16'h1800);
    check("basic_done_cyc", done_cyc, 12);
    check("basic_n_done", n_done, 1);
    check("basic_pc", seq_pc, 13'h105);
    check("basic_hold_op", {alu_opcode, alu_a}, 16'h1800);

    // three wait cycles on every fetch
    wait_cfg = 3;
    start_seq(13'h100, 8'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      #1;
      check($sformatf("wait_addr_c%0d", c), {mem_req, mem_addr},
            {1'b1, (c <= 4) ? 13'h100 : 13'h101});
    end
    wait_done("wait", 40);
    check("wait_en_cyc", en_cyc[0], 9);
    check("wait_issue", {en_op[0], en_a[0]}, 16'hA905);
    wait_cfg = 0;

    // pc wraps from 0x1FFF to 0x0000
    mem[13'h1FFF] = 8'hC9; mem[13'h0000] = 8'h7F;
    start_seq(13'h1FFF, 8'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check("wrap_arg_addr", {mem_req, mem_addr}, {1'b1, 13'h0000});
    wait_done("wrap", 30);
    check("wrap_issue", {en_op[0], en_a[0]}, 16'hC97F);
    check("wrap_pc", seq_pc, 13'h0001);

    // illegal opcodes 89, 02 then E8
    mem[13'h200] = 8'h89; mem[13'h201] = 8'h02; mem[13'h202] = 8'hE8;
    start_seq(13'h200, 8'd3);
    wait_done("illegal", 40);
    check("ill_count", n_ill, 2);
    check("ill_n_en", n_en, 1);
    check("ill_issue", {en_op[0], en_a[0]}, 16'hE800);
    check("ill_en_cyc", en_cyc[0], 6);
    check("ill_done_cyc", done_cyc, 8);

    // abort while the operand fetch is stalled
    mem[13'h300] = 8'hA9;
    block_addr = 13'h301;
    start_seq(13'h300, 8'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check("abort_stall", {mem_req, mem_addr}, {1'b1, 13'h301});
    @(negedge clk_i);
    seq_abort = 1'b1;
    @(posedge clk_i);
    #1;
    seq_abort = 1'b0;
    @(negedge clk_i);
    #1;
    check("abort_idle", {seq_busy, mem_req}, 0);
    repeat (5) @(negedge clk_i);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_no_issue", n_en, 0);
    block_addr = -1;

    // abort beats an ack in the same cycle: pc stays
    mem[13'h400] = 8'hA9;
    start_seq(13'h400, 8'd1);
    seq_abort = 1'b1;
    @(posedge clk_i);
    #1;
    seq_abort = 1'b0;
    @(negedge clk_i);
    #1;
    check("abort_ack_pc", seq_pc, 13'h400);
    check("abort_ack_busy", seq_busy, 0);

    // zero count
    start_seq(13'h500, 8'd0);
    @(negedge clk_i);
    #1;
    check("zero_done_c1", seq_done, 1);
    @(negedge clk_i);
    #1;
    check("zero_done_c2", seq_done, 0);
    check("zero_busy", busy_seen, 0);
    check("zero_n_done", n_done, 1);

    // asynchronous reset while stalled in FETCH_ARG
    block_addr = 13'h101;
    start_seq(13'h100, 8'd1);
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge clk_i);
        #1;
        if (mem_req && mem_addr == 13'h101) break;
      end
      check("rstmid_reach_arg", (k < 20) ? 1 : 0, 1);
    end
    #1;
    n_rst_i = 1'b0;
    #1;
    check("rstmid_outputs", {mem_req, alu_enable, seq_busy, seq_done, seq_illegal}, 0);
    check("rstmid_addr_pc", {mem_addr, seq_pc}, 0);
    check("rstmid_alu", {alu_opcode, alu_a}, 0);
    block_addr = -1;
    @(negedge clk_i);
    n_rst_i = 1'b1;
    clear_mon();
    repeat (6) @(negedge clk_i);
    #1;
    check("rstmid_no_issue", n_en, 0);
    check("rstmid_idle", {seq_busy, mem_req}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/t6507lp_alu_sequencer.md
# t6507lp_alu_sequencer

Upstream feeder for the T6507LP ALU. It fetches 6507 opcode/operand bytes from a byte-wide program memory over a req/ack handshake. It decodes instruction length and issues each instruction to the ALU as a one-cycle `alu_enable` pulse with stable `alu_opcode`/`alu_a`. It runs a host-specified number of instructions, then reports completion.

## Interface
- `ADDR_WIDTH`, 13: program address width (6507 bus); PC wraps modulo 2^ADDR_WIDTH.
- `GAP_CYCLES`, 1: idle cycles after each issue, giving the ALU time to settle; legal range 0..15.
- `clk_i` in 1: single clock, all state on rising edge.
- `n_rst_i` in 1: reset, asynchronous, active-low.
- `seq_start` in 1: start pulse, sampled only in IDLE.
- `seq_start_addr` in ADDR_WIDTH: first opcode address.
- `seq_count` in 8: number of instructions to process (legal and illegal both count).
- `seq_abort` in 1: return to IDLE, no done pulse.
- `mem_req` out 1: fetch request.
- `mem_addr` out ADDR_WIDTH: fetch address.
- `mem_ack` in 1: transfer complete; `mem_data` is valid in the same cycle.
- `mem_data` in 8: fetched byte.
- `alu_enable` out 1: one-cycle issue strobe to the ALU.
- `alu_opcode` out 8: issued opcode.
- `alu_a` out 8: issued operand (0x00 for 1-byte instructions).
- `seq_busy` out 1: high in any non-IDLE state.
- `seq_done` out 1: one-cycle completion pulse.
- `seq_illegal` out 1: one-cycle pulse on an unsupported opcode.
- `seq_pc` out ADDR_WIDTH: current PC.

## Operation
- **States:** IDLE, FETCH_OP, FETCH_ARG, ISSUE, GAP.
- **IDLE**
  - `seq_start` with `seq_count` != 0: pc <= `seq_start_addr`, remaining <= `seq_count`, go to FETCH_OP.
  - `seq_start` with `seq_count` == 0: `seq_done` pulses next cycle; stay in IDLE.
- **FETCH_OP**
  - `mem_req`=1, `mem_addr`=pc, both held stable until `mem_ack`.
  - On ack: opcode_r <= `mem_data`, pc <= pc+1 (wrapping), then decode:
  - **2-byte** (next state FETCH_ARG): opcode[4:0]==5'b01001 excluding 0x89 (i.e. 09,29,49,69,A9,C9,E9), or opcode in {A0,A2,C0,E0}.
  - **1-byte** (next state ISSUE, operand 0x00): opcode[3:0]==4'h8 or 4'hA.
  - **Otherwise illegal:** `seq_illegal` pulses, remaining decrements, no issue, go to GAP.
- **FETCH_ARG**
  - Same handshake at the new pc.
  - On ack: arg_r <= `mem_data`, pc <= pc+1, go to ISSUE.
- **ISSUE**
  - `alu_enable`=1 for exactly this cycle; `alu_opcode`/`alu_a` are registered and already valid.
  - remaining decrements.
  - Next state: GAP if `GAP_CYCLES`>0; otherwise apply the GAP exit rule directly.
- **GAP**
  - Counts `GAP_CYCLES` cycles.
  - Exit: remaining==0 goes to IDLE and `seq_done` pulses in the first IDLE cycle; otherwise go to FETCH_OP.
- **Output holding:** `alu_opcode`/`alu_a` hold the last issued values between issues.
- **`mem_req`:** drops only when leaving the FETCH states. Back-to-back FETCH_OP→FETCH_ARG keeps `mem_req` high with `mem_addr` advancing; memory must accept this.
- **Abort:** `seq_abort` in any non-IDLE state forces IDLE on the next edge.
  - `mem_req` and `alu_enable` drop; `seq_done` does not pulse.
  - An issue already in ISSUE in that cycle stands.
  - Abort has priority over `mem_ack` in the same cycle: the byte is discarded and pc does not advance.
- `seq_start` while busy is ignored.

## Timing
- **Reset values:** state IDLE; pc, remaining and gap counter 0. All outputs 0: `mem_req`, `mem_addr`, `alu_enable`, `alu_opcode`, `alu_a`, `seq_busy`, `seq_done`, `seq_illegal`, `seq_pc`.
- **Reset mid-operation:** immediate return to reset values, with no further fetch or issue.
- **Zero-wait latency:**
  - start sampled at edge 0; FETCH_OP in cycle 1;
  - 2-byte: FETCH_ARG in cycle 2, `alu_enable` in cycle 3;
  - 1-byte: `alu_enable` in cycle 2.
- Each wait cycle (req high, ack low) adds exactly one cycle.
- **Per-instruction cost (zero-wait):** 2-byte = 3 + `GAP_CYCLES`; 1-byte = 2 + `GAP_CYCLES`; illegal = 1 + `GAP_CYCLES`.
- `seq_illegal` is asserted in the cycle after the ack of the illegal opcode.
- `mem_ack` while `mem_req`=0 is ignored.

## Test plan
- **Reset:** assert `n_rst_i` low while in FETCH_ARG with `mem_req`=1 → all outputs 0 asynchronously; after release, state IDLE with no issue.
- **Basic program:** memory 0x0100..0x0104 = A9 05 69 03 18, zero-wait, `GAP_CYCLES`=1, start 0x0100, count 3 →
  - `alu_enable` in cycles 3, 7, 10 with (A9,05), (69,03), (18,00);
  - `seq_done` in cycle 12; `seq_pc`=0x0105.
- **Wait states:** ack delayed 3 cycles on every fetch for A9 05 → `mem_addr` stable 0x0100 then 0x0101 while waiting; `alu_enable` in cycle 9.
- **Address wrap:** start 0x1FFF, mem[0x1FFF]=C9, mem[0x0000]=7F, count 1 → second fetch at 0x0000; issue (C9,7F); `seq_pc`=0x0001.
- **Illegal opcodes:** 89 and 02 at 0x0200..0x0201, then E8, count 3 → two `seq_illegal` pulses with no `alu_enable`, then a single issue (E8,00), then `seq_done`.
- **Abort and zero count:**
  - abort during the FETCH_ARG wait → IDLE next cycle, `mem_req`=0, no `seq_done`, no issue;
  - start with `seq_count`=0 → `seq_done` in the next cycle, `seq_busy` never high.
